// File: rtl/fake_slave_pkg.sv
// Shared bus widths, cycle-type codes, request struct and FSM encoding for the
// fake WISHBONE B4 responder.
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
`define BUS_SEL_WIDTH (`BUS_DATA_WIDTH/8)
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif

package fake_slave_pkg;
    localparam int DATA_W  = `BUS_DATA_WIDTH;
    localparam int SEL_W   = `BUS_SEL_WIDTH;
    localparam int ADDR_W  = `BUS_ADDRESS_WIDTH;
    localparam int ADR_LSB = $clog2(SEL_W);

    localparam logic [2:0] CTI_CLASSIC   = 3'b000;
    localparam logic [2:0] CTI_INC_BURST = 3'b010;
    localparam logic [2:0] CTI_END_BURST = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_RESP  = 2'd2,
        S_BURST = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic              we;
        logic [DATA_W-1:0] dat;
        logic [SEL_W-1:0]  sel;
        logic [2:0]        cti;
    } bus_req_t;

    // Anything set above the word-index field falls outside the memory.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] adr, input int mem_bits);
        return (adr >> (ADR_LSB + mem_bits)) == '0;
    endfunction
endpackage

// File: rtl/fake_slave_if.sv
// WISHBONE B4 pipelined bus bundle between a master and the fake slave.
interface fake_slave_if;
    import fake_slave_pkg::*;

    logic              CYC_I;
    logic              STB_I;
    logic              WE_I;
    logic [DATA_W-1:0] DAT_I;
    logic [SEL_W-1:0]  SEL_I;
    logic [ADDR_W-1:0] ADR_I;
    logic [2:0]        CTI_I;
    logic [DATA_W-1:0] DAT_O;
    logic              ACK_O;
    logic              RTY_O;
    logic              ERR_O;
    logic              STALL_O;

    modport master (
        output CYC_I, STB_I, WE_I, DAT_I, SEL_I, ADR_I, CTI_I,
        input  DAT_O, ACK_O, RTY_O, ERR_O, STALL_O
    );

    modport slave (
        input  CYC_I, STB_I, WE_I, DAT_I, SEL_I, ADR_I, CTI_I,
        output DAT_O, ACK_O, RTY_O, ERR_O, STALL_O
    );
endinterface

// File: rtl/fake_slave_mem.sv
// Single-port word memory: byte write enables, asynchronous read, reset fill
// of INIT_PATTERN ^ index.
module fake_slave_mem
    import fake_slave_pkg::*;
#(
    parameter int                ADDR_BITS    = 4,
    parameter logic [DATA_W-1:0] INIT_PATTERN = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] idx,
    input  logic [SEL_W-1:0]     we,
    input  logic [DATA_W-1:0]    wdat,
    output logic [DATA_W-1:0]    rdat
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_PATTERN ^ DATA_W'(i);
        end else begin
            for (int b = 0; b < SEL_W; b++)
                if (we[b]) mem[idx][b*8 +: 8] <= wdat[b*8 +: 8];
        end
    end

    assign rdat = mem[idx];
endmodule

// File: rtl/fake_slave.sv
// WISHBONE B4 target with programmable wait states, periodic RTY, ERR on
// out-of-range addresses and single-cycle incrementing bursts.
module fake_slave
    import fake_slave_pkg::*;
#(
    parameter int                MEM_ADDR_BITS = 4,
    parameter int                WAIT_STATES   = 2,
    parameter int                RTY_PERIOD    = 0,
    parameter logic [DATA_W-1:0] INIT_PATTERN  = '0
) (
    input  logic         clk,
    input  logic         rst,
    fake_slave_if.slave  bus,
    output logic [15:0]  n_ack_o
);
    state_t                   state;
    bus_req_t                 in_req, lat_req, req;
    logic [3:0]               wait_cnt;
    logic [15:0]              rty_cnt;
    logic                     burst_next;
    logic                     issue, burst_beat, in_range;
    logic                     t_err, t_rty, t_ack;
    logic [SEL_W-1:0]         mem_we;
    logic [DATA_W-1:0]        mem_rdat;
    logic [MEM_ADDR_BITS-1:0] idx;
    logic                     ack_q, rty_q, err_q, stall_q;
    logic [DATA_W-1:0]        dat_q;

    assign in_req = {bus.ADR_I, bus.WE_I, bus.DAT_I, bus.SEL_I, bus.CTI_I};

    // Decide at each edge whether a termination is registered, and from
    // which request (live bus or the latched one while waiting).
    always_comb begin
        req        = lat_req;
        issue      = 1'b0;
        burst_beat = 1'b0;
        case (state)
            S_IDLE: begin
                req   = in_req;
                issue = bus.CYC_I && bus.STB_I && (WAIT_STATES == 0);
            end
            S_WAIT:  issue = bus.CYC_I && (wait_cnt == 4'd1);
            S_BURST: begin
                req        = in_req;
                issue      = bus.CYC_I && bus.STB_I;
                burst_beat = 1'b1;
            end
            default: ;
        endcase
        in_range = addr_in_range(req.adr, MEM_ADDR_BITS);
        idx      = req.adr[ADR_LSB +: MEM_ADDR_BITS];
        t_err    = issue && !in_range;
        t_rty    = issue && in_range && !burst_beat && (RTY_PERIOD != 0)
                   && (rty_cnt == 16'(RTY_PERIOD - 1));
        t_ack    = issue && in_range && !t_rty;
        mem_we   = (t_ack && req.we) ? req.sel : '0;
    end

    fake_slave_mem #(
        .ADDR_BITS    (MEM_ADDR_BITS),
        .INIT_PATTERN (INIT_PATTERN)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .idx  (idx),
        .we   (mem_we),
        .wdat (req.dat),
        .rdat (mem_rdat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            lat_req    <= '0;
            wait_cnt   <= '0;
            rty_cnt    <= '0;
            burst_next <= 1'b0;
            ack_q      <= 1'b0;
            rty_q      <= 1'b0;
            err_q      <= 1'b0;
            stall_q    <= 1'b0;
            dat_q      <= '0;
            n_ack_o    <= '0;
        end else begin
            ack_q <= t_ack;
            rty_q <= t_rty;
            err_q <= t_err;
            dat_q <= (t_ack && !req.we) ? mem_rdat : '0;
            if (t_ack) n_ack_o <= n_ack_o + 16'd1;
            if (t_ack && !burst_beat && (RTY_PERIOD != 0)) rty_cnt <= rty_cnt + 16'd1;
            else if (t_rty)                                rty_cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (bus.CYC_I && bus.STB_I) begin
                        lat_req <= in_req;
                        stall_q <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state      <= S_RESP;
                            burst_next <= t_ack && (in_req.cti == CTI_INC_BURST);
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_STATES);
                        end
                    end else begin
                        stall_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!bus.CYC_I) begin
                        state   <= S_IDLE;
                        stall_q <= 1'b0;
                    end else if (issue) begin
                        state      <= S_RESP;
                        burst_next <= t_ack && (lat_req.cti == CTI_INC_BURST);
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    stall_q <= 1'b0;
                    state   <= (bus.CYC_I && burst_next) ? S_BURST : S_IDLE;
                end
                S_BURST: begin
                    // Anything other than an incrementing beat closes the burst.
                    if (!bus.CYC_I || t_err || (t_ack && (req.cti != CTI_INC_BURST)))
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ACK_O   = ack_q;
    assign bus.RTY_O   = rty_q;
    assign bus.ERR_O   = err_q;
    assign bus.STALL_O = stall_q;
    assign bus.DAT_O   = dat_q;
endmodule
